vfp_frame_sequencer: RTL
========================

Name: vfp_frame_sequencer

Overview:
- Sequences one or more video frames through the VFP pixel path.
- Generates fvalid/lvalid/valid/sof/eof timing and x/y coordinates around a pixel source using a ready/valid handshake.
- Applies line blanking and back-pressure from the downstream consumer (iReadyToRead).
- Sits between the pattern/BMP pixel source and the VFP filter input; it is the run controller for the pattern_channel stream.

Parameters:
- IMG_WIDTH, 100, default pixels per line when cfg_width==0
- LVAL_OFFSET, 10, default blanking cycles when cfg_offset==0
- IMG_HEIGHT, 5, default lines per frame when cfg_lines==0
- NUM_FRAMES, 1, default frame count when cfg_frames==0
- DATA_WIDTH, 24, rgb width
- XY_WIDTH, 12, coordinate/config width

Ports:
- clk  in  1  system clock
- rst_l  in  1  asynchronous active-low reset
- start  in  1  run request pulse; sampled in IDLE only
- abort  in  1  synchronous abort; wins over all other events
- cfg_width  in  XY_WIDTH  pixels per line; 0 selects IMG_WIDTH
- cfg_offset  in  XY_WIDTH  blanking cycles; 0 selects LVAL_OFFSET
- cfg_lines  in  XY_WIDTH  lines per frame; 0 selects IMG_HEIGHT
- cfg_frames  in  8  frame count; 0 selects NUM_FRAMES
- src_valid  in  1  source pixel available
- src_data  in  DATA_WIDTH  source pixel
- src_ready  out  1  source pixel accepted this cycle when src_valid is high
- iReadyToRead  in  1  downstream ready
- valid  out  1  output pixel strobe
- lvalid  out  1  line valid
- fvalid  out  1  frame valid
- sof  out  1  first pixel of frame
- eof  out  1  last pixel of frame
- rgb  out  DATA_WIDTH  output pixel
- x  out  XY_WIDTH  pixel column
- y  out  XY_WIDTH  pixel row
- frame_cnt  out  8  frames completed in the current run
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset (rst_l=0, asynchronous): state=IDLE; all outputs 0, including src_ready, rgb, x, y and frame_cnt.
- Config capture:
  - Config is latched on the edge where start is accepted; zero fields are replaced by the parameter defaults.
  - Config changes during a run are ignored.
  - start while busy is ignored.
- IDLE: on start, go to H_BLANK with y=0 and frame_cnt=0. fvalid=1 is visible after that edge.
- H_BLANK: fvalid=1, lvalid=0. Count the latched offset cycles; this count is independent of iReadyToRead. Then go to ACTIVE.
- ACTIVE:
  - src_ready = iReadyToRead, combinational, asserted only in ACTIVE.
  - A transfer occurs when src_valid && src_ready.
  - On each transfer edge, register valid=1, rgb=src_data, x=pixel index, y=line index.
  - valid returns to 0 on the next edge unless another transfer occurs.
  - Stall cycles, i.e. no transfer: valid=0, lvalid held 1, x/rgb held.
  - lvalid=1 from the edge entering ACTIVE up to and including the cycle of the last pixel of the line; it drops on the following edge.
  - sof=1 together with the pixel at x=0,y=0; eof=1 together with the pixel at x=width-1,y=lines-1. Both are single-cycle.
- After the last pixel of a line:
  - If y<lines-1: increment the line index and go to H_BLANK.
  - Otherwise: increment frame_cnt and go to V_BLANK.
- V_BLANK:
  - fvalid=0 for the latched offset cycles.
  - If frame_cnt==frames: go to DONE.
  - Otherwise: go to H_BLANK with y=0, and fvalid rises again.
- DONE: done=1 for exactly one cycle, then IDLE. frame_cnt holds its value until the next start.
- Latency: one cycle from the source transfer edge to the valid/rgb output.
- Counter widths: internal counters are XY_WIDTH bits. width/lines/offset up to 2^XY_WIDTH-1 must work; no wrap-around within a line.
- Abort:
  - Next state is IDLE, with valid/lvalid/fvalid/sof/eof/src_ready=0 from that edge.
  - done is NOT pulsed; frame_cnt holds.
  - abort in IDLE has no effect.
  - abort and start in the same cycle: abort wins, no run starts.
- Reset mid-frame: immediate return to the reset state; no done pulse; src_ready drops asynchronously.
- Simultaneous events:
  - A transfer on the last pixel while iReadyToRead deasserts is still the last pixel.
  - src_valid without iReadyToRead never consumes a pixel.

Test Plan:
- Basic run: width=4, offset=2, lines=2, frames=1, src_valid=1, iReadyToRead=1 -> 8 valid pulses.
  - x sequence 0,1,2,3,0,1,2,3; y is 0 then 1.
  - sof with (0,0); eof with (3,1).
  - 2-cycle lvalid gap between lines; done pulses once; frame_cnt=1.
- Back-pressure: same config, iReadyToRead toggling 1,0,1,0 -> src_ready mirrors iReadyToRead in ACTIVE.
  - No duplicate or lost pixels: rgb equals the source sequence 0x000001..0x000008.
  - lvalid stays high through stalls.
- Defaults and multi-frame: all cfg=0 except frames=2 -> 100×5 pixels per frame, 10-cycle blanks.
  - fvalid low for 10 cycles between frames; frame_cnt 1 then 2; single done pulse.
- Abort mid-line at x=2,y=1 -> next cycle busy=0 and fvalid=lvalid=valid=0; no done pulse.
  - A following start yields sof at (0,0).
- Reset mid-frame: rst_l=0 during ACTIVE -> all outputs 0 immediately, without a clock edge.
  - After release, state is IDLE; start during the frame is ignored.
- Start while busy and config change mid-run: pulse start with cfg_width=7 during a run -> no restart; line length stays at the latched 4.

Source files
------------

// File: rtl/vfp_frame_sequencer.sv
// Frame/line timing generator around a ready/valid pixel source.
// Output pixels appear one cycle after the source transfer; downstream ready gates src_ready.
module vfp_frame_sequencer #(
  parameter int IMG_WIDTH   = 100,
  parameter int LVAL_OFFSET = 10,
  parameter int IMG_HEIGHT  = 5,
  parameter int NUM_FRAMES  = 1,
  parameter int DATA_WIDTH  = 24,
  parameter int XY_WIDTH    = 12
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  start,
  input  logic                  abort,
  input  logic [XY_WIDTH-1:0]   cfg_width,
  input  logic [XY_WIDTH-1:0]   cfg_offset,
  input  logic [XY_WIDTH-1:0]   cfg_lines,
  input  logic [7:0]            cfg_frames,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  input  logic                  iReadyToRead,
  output logic                  valid,
  output logic                  lvalid,
  output logic                  fvalid,
  output logic                  sof,
  output logic                  eof,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic [XY_WIDTH-1:0]   x,
  output logic [XY_WIDTH-1:0]   y,
  output logic [7:0]            frame_cnt,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HBLANK = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_VBLANK = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [XY_WIDTH-1:0] DEF_W   = XY_WIDTH'(IMG_WIDTH);
  localparam logic [XY_WIDTH-1:0] DEF_OFF = XY_WIDTH'(LVAL_OFFSET);
  localparam logic [XY_WIDTH-1:0] DEF_L   = XY_WIDTH'(IMG_HEIGHT);
  localparam logic [7:0]          DEF_F   = 8'(NUM_FRAMES);
  localparam logic [XY_WIDTH-1:0] ONE     = XY_WIDTH'(1);

  logic [2:0]            r_state, w_next;
  logic [XY_WIDTH-1:0]   r_width, r_offset, r_lines;
  logic [7:0]            r_frames;
  logic [XY_WIDTH-1:0]   r_cnt, r_px, r_line;
  logic                  r_valid, r_lvalid, r_fvalid, r_sof, r_eof, r_busy, r_done;
  logic [DATA_WIDTH-1:0] r_rgb;
  logic [XY_WIDTH-1:0]   r_x, r_y;
  logic [7:0]            r_frame_cnt;
  logic                  w_xfer, w_eol, w_eof_px, w_start, w_blank_end;

  assign src_ready   = (r_state == S_ACTIVE) && iReadyToRead;
  assign w_xfer      = src_valid && src_ready;
  assign w_eol       = w_xfer && (r_px == r_width - ONE);
  assign w_eof_px    = w_eol && (r_line == r_lines - ONE);
  assign w_start     = (r_state == S_IDLE) && start && !abort;
  assign w_blank_end = (r_cnt == r_offset);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_HBLANK;
      S_HBLANK: if (w_blank_end) w_next = S_ACTIVE;
      S_ACTIVE: if (w_eol) w_next = w_eof_px ? S_VBLANK : S_HBLANK;
      S_VBLANK: if (w_blank_end) w_next = (r_frame_cnt == r_frames) ? S_DONE : S_HBLANK;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // Blank counter loads 0 after a line so the trailing pixel cycle is not part of the gap.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= S_IDLE;
      r_width     <= '0;
      r_offset    <= '0;
      r_lines     <= '0;
      r_frames    <= '0;
      r_cnt       <= '0;
      r_px        <= '0;
      r_line      <= '0;
      r_valid     <= 1'b0;
      r_lvalid    <= 1'b0;
      r_fvalid    <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rgb       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_busy   <= (w_next != S_IDLE);
      r_done   <= (w_next == S_DONE);
      r_lvalid <= (w_next == S_ACTIVE) || (w_eol && !abort);
      r_fvalid <= (w_next == S_HBLANK) || (w_next == S_ACTIVE) || (w_eof_px && !abort);
      r_valid  <= w_xfer && !abort;
      r_sof    <= w_xfer && !abort && (r_px == '0) && (r_line == '0);
      r_eof    <= w_eof_px && !abort;
      if (!abort) begin
        if (w_start) begin
          r_width     <= (cfg_width  == '0) ? DEF_W   : cfg_width;
          r_offset    <= (cfg_offset == '0) ? DEF_OFF : cfg_offset;
          r_lines     <= (cfg_lines  == '0) ? DEF_L   : cfg_lines;
          r_frames    <= (cfg_frames == '0) ? DEF_F   : cfg_frames;
          r_px        <= '0;
          r_line      <= '0;
          r_frame_cnt <= '0;
          r_y         <= '0;
          r_cnt       <= ONE;
        end
        if ((r_state == S_HBLANK) || (r_state == S_VBLANK)) r_cnt <= r_cnt + ONE;
        if (w_xfer) begin
          r_rgb <= src_data;
          r_x   <= r_px;
          r_y   <= r_line;
          if (w_eol) begin
            r_px  <= '0;
            r_cnt <= '0;
            if (w_eof_px) r_frame_cnt <= r_frame_cnt + 8'd1;
            else          r_line      <= r_line + ONE;
          end else begin
            r_px <= r_px + ONE;
          end
        end
        if ((r_state == S_VBLANK) && (w_next == S_HBLANK)) begin
          r_cnt  <= ONE;
          r_line <= '0;
          r_y    <= '0;
        end
      end
    end
  end

  assign valid     = r_valid;
  assign lvalid    = r_lvalid;
  assign fvalid    = r_fvalid;
  assign sof       = r_sof;
  assign eof       = r_eof;
  assign rgb       = r_rgb;
  assign x         = r_x;
  assign y         = r_y;
  assign frame_cnt = r_frame_cnt;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
